// File: rtl/banked_sdp_buffer.sv
// Simple-dual-port buffer with per-lane write mask, 1/2-cycle read latency and a zero sweep after reset.
// Define BANKED_SDP_WRITE_FORWARD_EN to forward same-cycle same-address writes into the read data.
module banked_sdp_buffer #(
  parameter int unsigned LANE_WIDTH   = 8,
  parameter int unsigned LANES        = 16,
  parameter int unsigned RAM_DEPTH    = 256,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned W  = LANE_WIDTH * LANES,
  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_busy,
  input  logic             wea,
  input  logic [LANES-1:0] wmask,
  input  logic [AW-1:0]    addra,
  input  logic [W-1:0]     dina,
  input  logic             enb,
  input  logic [AW-1:0]    addrb,
  output logic [W-1:0]     doutb,
  output logic             doutb_valid,
  output logic             req_drop
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  mem [RAM_DEPTH];

  logic          wr_c;
  logic          rd_c;
  logic [W-1:0]  rd_word_c;

  // Sweep sequencing: one word zeroed per cycle, then park in RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(RAM_DEPTH - 1)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
      req_drop  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_busy <= (state_nxt == ST_INIT);
      req_drop  <= init_busy & (wea | enb);
    end
  end

  assign wr_c = wea & ~rst & (state == ST_RUN) & (32'(addra) < RAM_DEPTH);
  assign rd_c = enb & (state == ST_RUN);

  // Read word; out-of-range addresses read as zero.
  always_comb begin
    rd_word_c = '0;
    if (32'(addrb) < RAM_DEPTH) begin
      rd_word_c = mem[addrb];
`ifdef BANKED_SDP_WRITE_FORWARD_EN
      if (wr_c && (addra == addrb)) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (wmask[i]) rd_word_c[i*LANE_WIDTH +: LANE_WIDTH] = dina[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[cnt] <= '0;
      end else if (wr_c) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (wmask[i]) mem[addra][i*LANE_WIDTH +: LANE_WIDTH] <= dina[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [W-1:0] s1_data;
      logic         s1_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid    <= 1'b0;
          s1_data     <= '0;
          doutb_valid <= 1'b0;
          doutb       <= '0;
        end else begin
          s1_valid    <= rd_c;
          if (rd_c) s1_data <= rd_word_c;
          doutb_valid <= s1_valid;
          if (s1_valid) doutb <= s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          doutb_valid <= 1'b0;
          doutb       <= '0;
        end else begin
          doutb_valid <= rd_c;
          if (rd_c) doutb <= rd_word_c;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_banked_sdp_buffer.sv
// Bench for banked_sdp_buffer: latency-1 and latency-2 instances share stimulus and a word-level model.
module tb_banked_sdp_buffer;

  localparam int unsigned LW = 8;
  localparam int unsigned LN = 16;
  localparam int unsigned D  = 256;
  localparam int unsigned W  = LW * LN;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = W + 1;

  typedef logic [W-1:0] word_t;

  typedef struct {
    logic          w;
    logic [LN-1:0] m;
    logic [AW-1:0] aa;
    word_t         d;
    logic          e;
    logic [AW-1:0] ab;
    logic          ev1;
    word_t         ed1;
    logic          ev2;
    word_t         ed2;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, wea, enb;
  logic [LN-1:0] wmask;
  logic [AW-1:0] addra, addrb;
  word_t         dina;
  logic          busy1, v1, drop1, busy2, v2, drop2;
  word_t         dout1, dout2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  banked_sdp_buffer #(.LANE_WIDTH(LW), .LANES(LN), .RAM_DEPTH(D), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .init_busy(busy1), .wea(wea), .wmask(wmask), .addra(addra),
    .dina(dina), .enb(enb), .addrb(addrb), .doutb(dout1), .doutb_valid(v1), .req_drop(drop1));

  banked_sdp_buffer #(.LANE_WIDTH(LW), .LANES(LN), .RAM_DEPTH(D), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .init_busy(busy2), .wea(wea), .wmask(wmask), .addra(addra),
    .dina(dina), .enb(enb), .addrb(addrb), .doutb(dout2), .doutb_valid(v2), .req_drop(drop2));

  // Reference model state: contents, sweep progress, expected outputs per latency.
  word_t mmem [D];
  bit    m_busy;
  int    m_cnt;
  bit    m_drop;
  bit    e_v1, e_v2, p_v;
  word_t e_d1, e_d2, p_d;

  function automatic word_t merge(input word_t old, input word_t nw, input logic [LN-1:0] m);
    word_t bm;
    for (int i = 0; i < int'(LN); i++) bm[i*LW +: LW] = {LW{m[i]}};
    return (old & ~bm) | (nw & bm);
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit    rv;
    word_t rd;
    rv = 1'b0;
    rd = '0;
    if (rst) begin
      for (int i = 0; i < int'(D); i++) mmem[i] = '0;
      m_busy = 1'b1; m_cnt = 0; m_drop = 1'b0;
      e_v1 = 1'b0; e_d1 = '0; e_v2 = 1'b0; e_d2 = '0; p_v = 1'b0; p_d = '0;
      return;
    end
    if (m_busy) begin
      m_drop = wea | enb;
      m_cnt++;
      if (m_cnt == int'(D)) m_busy = 1'b0;
    end else begin
      m_drop = 1'b0;
      rv = enb;
      rd = mmem[addrb];
`ifdef BANKED_SDP_WRITE_FORWARD_EN
      if (wea && addra == addrb) rd = merge(rd, dina, wmask);
`endif
      if (wea) mmem[addra] = merge(mmem[addra], dina, wmask);
    end
    e_v1 = rv;
    if (rv) e_d1 = rd;
    e_v2 = p_v;
    if (p_v) e_d2 = p_d;
    p_v = rv;
    p_d = rd;
  endtask

  task automatic step(input logic r, input logic w, input logic [LN-1:0] m, input logic [AW-1:0] aa,
                      input word_t d, input logic e, input logic [AW-1:0] ab);
    rst = r; wea = w; wmask = m; addra = aa; dina = d; enb = e; addrb = ab;
    @(posedge clk);
    model_edge();
    #1;
    check("lat1_out", {v1, dout1}, {e_v1, e_d1});
    check("lat2_out", {v2, dout2}, {e_v2, e_d2});
    check("init_busy", CW'({busy2, busy1}), CW'({m_busy, m_busy}));
    check("req_drop", CW'({drop2, drop1}), CW'({m_drop, m_drop}));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Counts cycles until init_busy falls; pulses a dropped request at sweep cycle 10.
  task automatic sweep_len(output int n);
    n = 0;
    while (busy1 && n < 400) begin
      if (n == 10) step(1'b0, 1'b1, '1, 8'd7, '1, 1'b1, 8'd7);
      else idle();
      n++;
    end
  endtask

  localparam word_t A5  = 128'hAAAAAAAA_AAAAAAAA_55555555_AAAAAAAA;
  localparam word_t W11 = {16{8'h11}};
  localparam word_t W22 = {16{8'h22}};
  localparam word_t W01 = {16{8'h01}};
  localparam word_t W02 = {16{8'h02}};
  localparam word_t W03 = {16{8'h03}};
`ifdef BANKED_SDP_WRITE_FORWARD_EN
  localparam word_t FWD = W22;
`else
  localparam word_t FWD = W11;
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [17];
    int   n;

    tbl[0]  = '{1'b1, 16'hFFFF, 8'd5, {16{8'hAA}}, 1'b0, 8'd0,   1'b0, '0,  1'b0, '0};
    tbl[1]  = '{1'b1, 16'h00F0, 8'd5, {16{8'h55}}, 1'b0, 8'd0,   1'b0, '0,  1'b0, '0};
    tbl[2]  = '{1'b0, 16'h0000, 8'd0, '0,          1'b1, 8'd5,   1'b1, A5,  1'b0, '0};
    tbl[3]  = '{1'b0, 16'h0000, 8'd0, '0,          1'b1, 8'd0,   1'b1, '0,  1'b1, A5};
    tbl[4]  = '{1'b0, 16'h0000, 8'd0, '0,          1'b1, 8'd128, 1'b1, '0,  1'b1, '0};
    tbl[5]  = '{1'b0, 16'h0000, 8'd0, '0,          1'b1, 8'd255, 1'b1, '0,  1'b1, '0};
    tbl[6]  = '{1'b1, 16'hFFFF, 8'd9, W11,         1'b0, 8'd0,   1'b0, '0,  1'b1, '0};
    tbl[7]  = '{1'b1, 16'hFFFF, 8'd9, W22,         1'b1, 8'd9,   1'b1, FWD, 1'b0, '0};
    tbl[8]  = '{1'b0, 16'h0000, 8'd0, '0,          1'b1, 8'd9,   1'b1, W22, 1'b1, FWD};
    tbl[9]  = '{1'b0, 16'h0000, 8'd0, '0,          1'b0, 8'd0,   1'b0, W22, 1'b1, W22};
    tbl[10] = '{1'b1, 16'hFFFF, 8'd1, W01,         1'b1, 8'd5,   1'b1, A5,  1'b0, W22};
    tbl[11] = '{1'b1, 16'hFFFF, 8'd2, W02,         1'b0, 8'd0,   1'b0, A5,  1'b1, A5};
    tbl[12] = '{1'b1, 16'hFFFF, 8'd3, W03,         1'b0, 8'd0,   1'b0, A5,  1'b0, A5};
    tbl[13] = '{1'b0, 16'h0000, 8'd0, '0,          1'b1, 8'd1,   1'b1, W01, 1'b0, A5};
    tbl[14] = '{1'b0, 16'h0000, 8'd0, '0,          1'b1, 8'd2,   1'b1, W02, 1'b1, W01};
    tbl[15] = '{1'b0, 16'h0000, 8'd0, '0,          1'b1, 8'd3,   1'b1, W03, 1'b1, W02};
    tbl[16] = '{1'b0, 16'h0000, 8'd0, '0,          1'b0, 8'd0,   1'b0, W03, 1'b1, W03};

    // Reset, then sweep length with a dropped request mid-sweep; swept words read as zero.
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    check("reset_dout", {v1, dout1}, '0);
    sweep_len(n);
    check("init_len", CW'(n), CW'(D));
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd7);
    check("dropped_wr", {v1, dout1}, {1'b1, word_t'(0)});
    idle();
    idle();

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].w, tbl[i].m, tbl[i].aa, tbl[i].d, tbl[i].e, tbl[i].ab);
      check($sformatf("tbl%0d_lat1", i), {v1, dout1}, {tbl[i].ev1, tbl[i].ed1});
      check($sformatf("tbl%0d_lat2", i), {v2, dout2}, {tbl[i].ev2, tbl[i].ed2});
    end

    // Reset with a latency-2 read in flight, then a second reset at sweep count 100.
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd9);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    check("flush_lat2", {v2, dout2}, '0);
    for (int i = 0; i < 100; i++) idle();
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    sweep_len(n);
    check("reinit_len", CW'(n), CW'(D));
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd9);
    check("cleared_9", {v1, dout1}, {1'b1, word_t'(0)});
    idle();

    // Random traffic on a narrow address window to force same-address collisions.
    for (int i = 0; i < 2000; i++) begin
      logic [AW-1:0] aa, ab;
      aa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      ab = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      step(1'b0, 1'($urandom), LN'($urandom), aa, {$urandom, $urandom, $urandom, $urandom},
           1'($urandom), ab);
      if ($urandom_range(0, 999) == 0) step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_sdp_buffer.md
Name: banked_sdp_buffer

Overview:
- Parametrised simple-dual-port buffer: one write port, one read port, single clock.
- Successor to the plain SDP block, with these additions:
  - per-lane (byte) write mask;
  - selectable read latency (1 or 2) with a read-valid strobe;
  - hardware zero-initialisation sweep after reset, so there is no dependence on initial blocks.
- Used as the unified/weight buffer feeding the systolic array; the lane mask allows partial-row updates from the DMA path.

Parameters:
- LANE_WIDTH, 8, bits per lane.
- LANES, 16, lanes per word; word width W = LANE_WIDTH*LANES.
- RAM_DEPTH, 256, number of words; AW = clog2(RAM_DEPTH), minimum 1.
- READ_LATENCY, 1, legal values 1 or 2; 2 adds an output register stage.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the zero-sweep runs; all requests are ignored while high.
- wea  in  1  write enable.
- wmask  in  LANES  lane write mask; bit i enables lane i (bits [i*LANE_WIDTH +: LANE_WIDTH]).
- addra  in  AW  write address.
- dina  in  W  write data.
- enb  in  1  read enable.
- addrb  in  AW  read address.
- doutb  out  W  read data.
- doutb_valid  out  1  one-cycle strobe marking new doutb.
- req_drop  out  1  one-cycle pulse when wea or enb was asserted while init_busy=1.

Behaviour:
- Reset values: doutb=0, doutb_valid=0, req_drop=0, init_busy=1, sweep counter=0, state=INIT.
- FSM, INIT:
  - Each cycle after rst deasserts, writes 0 to mem[cnt] and increments cnt.
  - When cnt==RAM_DEPTH-1 is written, moves to RUN.
  - init_busy drops exactly RAM_DEPTH cycles after the first cycle with rst=0.
- FSM, RUN:
  - Normal operation; stays in RUN until rst.
- rst asserted in any state, including mid-sweep or mid-read:
  - Returns to INIT with cnt=0.
  - Discards in-flight read pipeline stages; doutb_valid=0 next cycle.
  - Restarts the full sweep.
- Write (RUN, wea=1):
  - For each i with wmask[i]=1, lane i of mem[addra] takes dina lane i; other lanes are unchanged.
  - wmask=0 is a legal no-op.
- Read (RUN, enb=1 at edge N):
  - READ_LATENCY=1: doutb=mem[addrb] and doutb_valid=1 after edge N (visible cycle N+1).
  - READ_LATENCY=2: doutb and doutb_valid appear one cycle later.
  - Back-to-back reads are fully pipelined, one per cycle.
- doutb holds its last value when no read completes; doutb_valid is 0 in those cycles.
- Requests during INIT: no memory write, no read issued; req_drop=1 the following cycle.
- Read and write to different addresses in the same cycle: independent.
- Same-address read and write in the same cycle: see Optional Feature.
- Addresses >= RAM_DEPTH (non-power-of-two depth): writes are ignored; reads return 0 with doutb_valid=1.
- Address arithmetic is unsigned, no wrap logic inside the block.

Optional Feature:
- Macro: BANKED_SDP_WRITE_FORWARD_EN.
- Defined: a same-cycle same-address read returns the merged word: masked lanes from dina, unmasked lanes from old mem contents. Latency is unchanged.
- Undefined: a same-cycle same-address read returns the old contents (read-first). Memory is still updated with the new data.

Test Plan:
- Reset, then hold rst=0 with RAM_DEPTH=256 -> init_busy=1 for exactly 256 cycles then 0; reads of addresses 0, 128 and 255 return 0 with doutb_valid after READ_LATENCY cycles.
- Write addra=5, dina=all lanes 0xAA, wmask=0xFFFF; then write addra=5, dina=all lanes 0x55, wmask=0x00F0; read addrb=5 -> lanes 4..7=0x55, other lanes 0xAA.
- Read addrb=1,2,3 on consecutive cycles with READ_LATENCY=2 -> doutb_valid high for 3 consecutive cycles starting 2 cycles after the first enb, with data in order.
- Write addr 9 with 0x11 per lane, then same-cycle wea/enb at addr 9 with 0x22 per lane and full mask -> 0x11 per lane without the macro, 0x22 per lane with it; a subsequent read returns 0x22 in both builds.
- Assert rst for 1 cycle at sweep count 100, with a read in flight -> doutb_valid=0, init_busy stays high for 256 cycles after release; previously written addr 9 reads 0.
- During init, pulse wea=1 and enb=1 -> req_drop=1 one cycle later, no doutb_valid, target word reads 0 after init completes.
